jt900h_eagen: RTL
=================

# jt900h_eagen

Parametrised effective-address generator for the JT900H core, successor to the single-width indexed-address unit. Decodes a stable 32-bit operand window for all TLCS-900H memory addressing modes, reads base/index registers from the register bank with a configurable read latency, and returns the effective address with a done pulse. Pointer update for (-r32)/(r32+) is computed here and issued as a register write-back, not left to the bank. Sits between the instruction decoder and the bus/ALU address mux.

## Interface
- `AW`, 24: effective-address width; all address arithmetic is modulo 2^AW.
- `RD_LAT`, 1: register-bank read latency in cen cycles, 1..3.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cen`  in  1  clock enable; no state changes while low.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  32  operand window, `op[7:0]` first byte; held stable until `done`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `ea`, `fetched`, `err` are valid.
- `ea`  out  AW  effective address; held until the next `done`.
- `fetched`  out  3  bytes consumed from `op`, 1..4.
- `err`  out  1  undefined mode; valid with `done`.
- `rd_sel`, `rd_aux_sel`  out  8  base / index register codes; NULL=8'h40 when unused.
- `rd_data`  in  32  base register value.
- `rd_aux`  in  16  index register value.
- `wb_en`  out  1  one-cycle pulse, coincident with `done`.
- `wb_sel`  out  8  write-back register code.
- `wb_data`  out  32  updated pointer value.

## Operation
- Mode key is `{op[6],op[3:0]}`. Full-register code for `rrr` is `8'hE0+4*rrr` (XWA..XSP).
- `0_0rrr` (r32): `ea=R`, fetched 1. `0_1rrr` (r32+d8): `d8=op[15:8]` sign-extended, fetched 2.
- `1_0000` / `1_0001` / `1_0010` absolute:
  - `ea` zero-extended from `op[15:8]`, `op[23:8]` or `op[31:8]`.
  - fetched 2 / 3 / 4.
  - No register read; `rd_sel` stays NULL.
- `1_0011`: base register = `{op[15:10],2'b00}`.
  - `op[9:8]`=0: (r32), fetched 2.
  - `op[9:8]`=1: (r32+d16), `d16=op[31:16]` sign-extended, fetched 4.
  - `op[9:8]`=3: base=`op[23:16]`, index=`op[31:24]` on `rd_aux_sel`, fetched 4.
    - `op[10]`=0: `rd_aux[7:0]` sign-extended.
    - `op[10]`=1: `rd_aux` sign-extended.
  - `op[9:8]`=2: err.
- `1_0100` (-r32) / `1_0101` (r32+): base `{op[15:10],2'b00}`, `step=1<<op[9:8]`, fetched 2.
  - Pre-decrement: `ea=R-step`, `wb_data=R-step`.
  - Post-increment: `ea=R`, `wb_data=R+step`.
  - `wb_sel`=base register. `op[9:8]`=3 is err.
- Any other key: `err`=1, `ea`=0, fetched 1, no write-back.
- `ea` uses `R[AW-1:0]`. `wb_data` is computed on the full 32 bits, modulo 2^32.
- FSM, all transitions on cen cycles:
  - IDLE: on `start`, go to RD for register modes, or CALC for absolute/err.
  - RD: drive `rd_sel`/`rd_aux_sel`, count RD_LAT cycles, then go to CALC.
  - CALC: capture and sum, pulse `done` (plus `wb_en` if applicable), return to IDLE.

## Timing
- Cycle numbering counts cen-active cycles; cycle 0 is the one sampling `start`.
- Register modes:
  - `rd_sel` valid from cycle 1.
  - `rd_data` sampled at cycle RD_LAT.
  - `done` at cycle 1+RD_LAT (cycle 2 at RD_LAT=1).
- Absolute and err: `done` at cycle 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive. Back-to-back: `start` may be sampled in the `done` cycle.
- `start` while `busy`=1 is ignored.
- `cen` low freezes the FSM, counters and outputs. `done`/`wb_en` stretch while `cen` is low.
- Reset values: `busy`/`done`/`err`/`wb_en` 0; `ea`/`fetched`/`wb_data` 0; `wb_sel` 0; `rd_sel`/`rd_aux_sel` NULL.
- `rst_n` low mid-operation aborts immediately to IDLE with reset values and no write-back.

## Structure
- Package `jt900h_ea_pkg` holds:
  - the NULL constant;
  - mode-key localparams;
  - the FSM state enum (IDLE/RD/CALC);
  - the `fullreg(rrr)` function.
- One sub-module, `jt900h_ea_alu`, is combinational. It takes base, offset and step, and produces `ea` (AW bits) and `wb_data` (32 bits).

## Test plan
All scenarios use AW=24, RD_LAT=1.
- XHL displacement: `op[7:0]`=0x0B, `op[15:8]`=0xFE, reg E0xEC=0x00001000 -> `rd_sel`=0xEC, `ea`=0x000FFE, fetched 2, `done` at cycle 2.
- Absolute 24: `op`=0x56341242 -> `ea`=0x563412, fetched 4, `done` at cycle 1, `rd_sel`=0x40 throughout.
- Pre-decrement: `op[15:0]`=0xF244, XIX=0x00002000 -> `ea`=0x001FFC, `wb_en`=1, `wb_sel`=0xF0, `wb_data`=0x00001FFC.
- Index r16: `op`=0xE0E80743, base=0x00FFFFF0, `rd_aux`=0x0020 -> `ea`=0x000010 (wrap), fetched 4, `rd_aux_sel`=0xE0.
- Undefined `op[7:0]`=0x47 -> `err`=1, `ea`=0, fetched 1, no `wb_en`. A `start` during the next operation's `busy` is ignored.
- Stall/reset: `cen` low for 3 cycles during RD -> `done` delayed by exactly 3. `rst_n` low in RD -> all outputs return to reset values and no `wb_en` occurs.

Source files
------------

// File: rtl/jt900h_ea_pkg.sv
// jt900h effective-address generator: shared constants, mode keys,
// FSM state type and the full-register code helper.
package jt900h_ea_pkg;

   localparam logic [7:0] NULL_REG  = 8'h40;

   localparam logic [4:0] K_ABS8    = 5'b1_0000;
   localparam logic [4:0] K_ABS16   = 5'b1_0001;
   localparam logic [4:0] K_ABS24   = 5'b1_0010;
   localparam logic [4:0] K_EXT     = 5'b1_0011;
   localparam logic [4:0] K_PREDEC  = 5'b1_0100;
   localparam logic [4:0] K_POSTINC = 5'b1_0101;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      CALC
   } state_t;

   // XWA..XSP live at E0, E4, ... FC
   function automatic logic [7:0] fullreg(input logic [2:0] rrr);
      return 8'hE0 + {3'b000, rrr, 2'b00};
   endfunction

endpackage

// File: rtl/jt900h_ea_alu.sv
// jt900h address adder: base plus offset for the effective address,
// base plus signed step for the pointer write-back value.
module jt900h_ea_alu #(
   parameter int AW = 24
) (
   input  logic [31:0]   base,
   input  logic [AW-1:0] offset,
   input  logic [31:0]   step,
   output logic [AW-1:0] ea,
   output logic [31:0]   wb_data
);

   assign ea      = base[AW-1:0] + offset;
   assign wb_data = base + step;

endmodule

// File: rtl/jt900h_eagen.sv
// jt900h effective-address generator: decodes the operand window,
// reads base/index registers and returns the address with a done pulse.
module jt900h_eagen
   import jt900h_ea_pkg::*;
#(
   parameter int AW     = 24,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          start,
   input  logic [31:0]   op,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] ea,
   output logic [2:0]    fetched,
   output logic          err,
   output logic [7:0]    rd_sel,
   output logic [7:0]    rd_aux_sel,
   input  logic [31:0]   rd_data,
   input  logic [15:0]   rd_aux,
   output logic          wb_en,
   output logic [7:0]    wb_sel,
   output logic [31:0]   wb_data
);

   state_t        state, nxt;
   logic [1:0]    cnt;
   logic          last, cap;

   logic [4:0]    key;
   logic          need_rd, aux_en, aux_wide, wb_mode, bad;
   logic [7:0]    base_code, aux_code;
   logic [AW-1:0] disp, aux_off, offs;
   logic [31:0]   mag, stp, abs_val, base;
   logic [2:0]    fet;

   logic [AW-1:0] alu_ea;
   logic [31:0]   alu_wb;
   logic          wb_q;

   // opcode bits that never take part in the mode key
   logic          unused_bits;
   assign unused_bits = ^{op[7], op[5:4]};

   assign key = {op[6], op[3:0]};
   assign mag = 32'd1 << op[9:8];

   // decode the mode key into register codes, offsets and length
   always_comb begin
      need_rd   = 1'b0;
      aux_en    = 1'b0;
      aux_wide  = 1'b0;
      wb_mode   = 1'b0;
      bad       = 1'b0;
      base_code = {op[15:10], 2'b00};
      aux_code  = op[31:24];
      disp      = '0;
      stp       = '0;
      abs_val   = '0;
      fet       = 3'd1;
      if (!op[6]) begin
         need_rd   = 1'b1;
         base_code = fullreg(op[2:0]);
         if (op[3]) begin
            disp = AW'($signed(op[15:8]));
            fet  = 3'd2;
         end
      end else begin
         case (key)
            K_ABS8: begin
               abs_val = {24'h0, op[15:8]};
               fet     = 3'd2;
            end
            K_ABS16: begin
               abs_val = {16'h0, op[23:8]};
               fet     = 3'd3;
            end
            K_ABS24: begin
               abs_val = {8'h0, op[31:8]};
               fet     = 3'd4;
            end
            K_EXT: begin
               fet = 3'd4;
               case (op[9:8])
                  2'd0: begin
                     need_rd = 1'b1;
                     fet     = 3'd2;
                  end
                  2'd1: begin
                     need_rd = 1'b1;
                     disp    = AW'($signed(op[31:16]));
                  end
                  2'd3: begin
                     need_rd   = 1'b1;
                     aux_en    = 1'b1;
                     aux_wide  = op[10];
                     base_code = op[23:16];
                  end
                  default: begin
                     bad = 1'b1;
                     fet = 3'd1;
                  end
               endcase
            end
            K_PREDEC, K_POSTINC: begin
               if (op[9:8] == 2'd3) begin
                  bad = 1'b1;
               end else begin
                  need_rd = 1'b1;
                  wb_mode = 1'b1;
                  fet     = 3'd2;
                  if (!op[0]) begin
                     disp = -mag[AW-1:0];
                     stp  = -mag;
                  end else begin
                     stp  = mag;
                  end
               end
            end
            default: bad = 1'b1;
         endcase
      end
   end

   assign aux_off = aux_wide ? AW'($signed(rd_aux))
                             : AW'($signed(rd_aux[7:0]));
   assign offs    = aux_en ? aux_off : disp;
   assign base    = need_rd ? rd_data : abs_val;

   jt900h_ea_alu #(.AW(AW)) u_alu (
      .base    (base),
      .offset  (offs),
      .step    (stp),
      .ea      (alu_ea),
      .wb_data (alu_wb)
   );

   assign last = (cnt == 2'(RD_LAT - 1));
   assign cap  = cen && ((state != RD && start && !need_rd) ||
                         (state == RD && last));

   // next-state logic; a new start is accepted in the done cycle too
   always_comb begin
      nxt = state;
      case (state)
         IDLE, CALC: begin
            if (start) nxt = need_rd ? RD : CALC;
            else       nxt = IDLE;
         end
         RD:      if (last) nxt = CALC;
         default: nxt = IDLE;
      endcase
   end

   // state and read-latency counter, frozen while cen is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (cen) begin
         state <= nxt;
         cnt   <= (state == RD && !last) ? cnt + 2'd1 : 2'd0;
      end
   end

   // capture results on the edge that enters the done cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ea      <= '0;
         fetched <= '0;
         err     <= 1'b0;
         wb_q    <= 1'b0;
         wb_sel  <= '0;
         wb_data <= '0;
      end else if (cap) begin
         ea      <= alu_ea;
         fetched <= fet;
         err     <= bad;
         wb_q    <= wb_mode;
         if (wb_mode) begin
            wb_sel  <= base_code;
            wb_data <= alu_wb;
         end
      end
   end

   assign busy       = (state != IDLE);
   assign done       = (state == CALC);
   assign wb_en      = done && wb_q;
   assign rd_sel     = (state == RD) ? base_code : NULL_REG;
   assign rd_aux_sel = (state == RD && aux_en) ? aux_code : NULL_REG;

endmodule
